// File: rtl/adc_capture_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | adc_capture_if: valid/ready sample stream out of the ADC capture   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
interface adc_capture_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface
`default_nettype wire

// File: rtl/adc_capture.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | adc_capture: ADC clock/strobe, offset-binary to signed, frame FIFO |
// | Optional macro ADC_DC_BIAS_EN: saturating DC_BIAS subtraction.     |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module adc_capture #(
  parameter int                         DATA_W     = 10,
  parameter int                         DIV        = 4,
  parameter int                         FRAME_LEN  = 1024,
  parameter int                         FIFO_DEPTH = 16,
  parameter logic signed [DATA_W-1:0]   DC_BIAS    = '0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DATA_W-1:0] adc_data,
  output logic                   adc_clk,
  input  wire logic              start,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  input  wire logic              ovf_clr,
  adc_capture_if.master          m
);

  localparam int c_DIV_W = $clog2(DIV);
  localparam int c_CNT_W = $clog2(FRAME_LEN);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(DIV / 2);
  localparam logic [c_DIV_W-1:0] c_STROBE   = c_DIV_W'(DIV / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(FRAME_LEN - 1);
  localparam logic [c_OCC_W-1:0] c_FULL     = c_OCC_W'(FIFO_DEPTH);

  generate
    if (DIV < 4 || (DIV % 2) != 0 || FRAME_LEN < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || $bits(DC_BIAS) != DATA_W) begin : g_bad_params
      $error("adc_capture: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_DIV_W-1:0]  r_div_cnt;
  logic                r_adc_clk;
  logic [DATA_W-1:0]   r_adc_q;
  logic [c_CNT_W-1:0]  r_samp_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [DATA_W:0]     r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_OCC_W-1:0]  r_mem_cnt;

  logic [c_DIV_W-1:0]  w_div_nxt;
  logic                w_strobe;
  logic [DATA_W-1:0]   w_s;
  logic [DATA_W-1:0]   w_sample;
  logic [c_OCC_W-1:0]  w_occ;
  logic                w_full;
  logic                w_pop;
  logic                w_capt;
  logic                w_push;
  logic                w_drop;
  logic                w_load;
  logic                w_is_last;

  assign w_div_nxt = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
  assign w_strobe  = (r_div_cnt == c_STROBE);
  assign w_s       = {~r_adc_q[DATA_W-1], r_adc_q[DATA_W-2:0]};

`ifdef ADC_DC_BIAS_EN
  logic [DATA_W:0] w_diff;
  assign w_diff   = {w_s[DATA_W-1], w_s} - {DC_BIAS[DATA_W-1], DC_BIAS};
  // Top two bits disagree only when the DATA_W+1 result left the DATA_W range.
  assign w_sample = (w_diff[DATA_W] != w_diff[DATA_W-1]) ?
                    {w_diff[DATA_W], {(DATA_W-1){~w_diff[DATA_W]}}} :
                    w_diff[DATA_W-1:0];
`else
  assign w_sample = w_s;
`endif

  // Occupancy counts the output register too, so FIFO_DEPTH is the total capacity.
  assign w_occ     = r_mem_cnt + {{c_PTR_W{1'b0}}, m.m_valid};
  assign w_full    = (w_occ == c_FULL);
  assign w_pop     = m.m_valid & m.m_ready;
  assign w_capt    = (r_state == ST_CAPTURE) && w_strobe;
  assign w_push    = w_capt && (!w_full || w_pop);
  assign w_drop    = w_capt && w_full && !w_pop;
  assign w_load    = (!m.m_valid || w_pop) && (r_mem_cnt != '0);
  assign w_is_last = (r_samp_cnt == c_LAST_IDX);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_is_last, w_sample};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_div_cnt  <= '0;
      r_adc_clk  <= 1'b0;
      r_adc_q    <= '0;
      r_samp_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_cnt  <= '0;
      m.m_valid  <= 1'b0;
      m.m_last   <= 1'b0;
      m.m_data   <= '0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_adc_clk <= (w_div_nxt >= c_DIV_HALF);
      r_adc_q   <= adc_data;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        m.m_data  <= r_mem[r_rd_ptr][DATA_W-1:0];
        m.m_last  <= r_mem[r_rd_ptr][DATA_W];
        m.m_valid <= 1'b1;
      end else if (w_pop) begin
        m.m_valid <= 1'b0;
        m.m_last  <= 1'b0;
      end
      case ({w_push, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + 1'b1;
        2'b01:   r_mem_cnt <= r_mem_cnt - 1'b1;
        default: r_mem_cnt <= r_mem_cnt;
      endcase

      if (ovf_clr) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end

      r_done <= (r_state == ST_DRAIN) && !r_done && w_pop && m.m_last;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_CAPTURE;
            r_samp_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (w_drop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_push && w_is_last) begin
            r_state <= ST_DRAIN;
          end else if (w_push) begin
            r_samp_cnt <= r_samp_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_clk  = r_adc_clk;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule
`default_nettype wire
